// File: rtl/lsu_defs_pkg.sv
// Shared LSU definitions: access size codes, FSM state encoding and timeout default.
// Also used by the control-path decoder.
package lsu_defs_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = lo[0];
      SIZE_W:  mis = (lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational byte-lane logic: store strobes and replication, load lane select
// with sign/zero extension.
module lsu_align
  import lsu_defs_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sign;

  // Store strobes and lane replication
  always_comb begin
    st_strb = 4'b0000;
    st_data = st_wdata;
    case (st_size)
      SIZE_B: begin
        st_strb = 4'b0001 << st_addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      SIZE_H: begin
        st_strb = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_data = {2{st_wdata[15:0]}};
      end
      SIZE_W: begin
        st_strb = 4'b1111;
        st_data = st_wdata;
      end
      default: begin
        st_strb = 4'b0000;
        st_data = 32'h0000_0000;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    ld_byte = 8'h00;
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_sign = 1'b0;
    ld_data = 32'h0000_0000;
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_rdata[7:0];
      2'b01:   ld_byte = ld_rdata[15:8];
      2'b10:   ld_byte = ld_rdata[23:16];
      2'b11:   ld_byte = ld_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    case (ld_size)
      SIZE_B: begin
        ld_sign = ~ld_unsigned & ld_byte[7];
        ld_data = {{24{ld_sign}}, ld_byte};
      end
      SIZE_H: begin
        ld_sign = ~ld_unsigned & ld_half[15];
        ld_data = {{16{ld_sign}}, ld_half};
      end
      SIZE_W: begin
        ld_sign = 1'b0;
        ld_data = ld_rdata;
      end
      default: begin
        ld_sign = 1'b0;
        ld_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: single-outstanding ready-handshaked bus access with
// lane steering. Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl
  import lsu_defs_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_we_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic [31:0]       bus_rdata_i
);

  lsu_state_e  state_r;
  logic [1:0]  lo_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic        we_r;
  logic [3:0]  st_strb_s;
  logic [31:0] st_data_s;
  logic [31:0] ld_data_s;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_r;
`else
  assign bus_err_o = 1'b0;
`endif

  lsu_align u_align (
    .st_size     (mem_size_i),
    .st_addr_lo  (addr_i[1:0]),
    .st_wdata    (wdata_i),
    .st_strb     (st_strb_s),
    .st_data     (st_data_s),
    .ld_size     (size_r),
    .ld_addr_lo  (lo_r),
    .ld_unsigned (uns_r),
    .ld_rdata    (bus_rdata_i),
    .ld_data     (ld_data_s)
  );

  // Reset gating keeps stall low while the unit is held in reset
  assign stall_o = ~rst_n & (((state_r == ST_IDLE) & mem_req_i) | (state_r == ST_BUSY));

  // Access FSM with registered bus and result outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      lo_r        <= 2'b00;
      size_r      <= SIZE_B;
      uns_r       <= 1'b0;
      we_r        <= 1'b0;
      rdata_o     <= 32'h0000_0000;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= '0;
      bus_we_o    <= 4'b0000;
      bus_wdata_o <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
      bus_err_o   <= 1'b0;
      cnt_r       <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          bus_err_o  <= 1'b0;
`endif
          if (mem_req_i) begin
            lo_r   <= addr_i[1:0];
            size_r <= mem_size_i;
            uns_r  <= mem_unsigned_i;
            we_r   <= mem_we_i;
            if (is_misaligned(mem_size_i, addr_i[1:0])) begin
              state_r    <= ST_DONE;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
              rdata_o    <= 32'h0000_0000;
            end else begin
              state_r     <= ST_BUSY;
              bus_req_o   <= 1'b1;
              bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              bus_we_o    <= mem_we_i ? st_strb_s : 4'b0000;
              bus_wdata_o <= st_data_s;
`ifdef LSU_TIMEOUT_EN
              cnt_r       <= '0;
`endif
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // A ready arriving on the limit cycle still completes normally
          if (bus_ready_i) begin
            state_r   <= ST_DONE;
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            if (!we_r) begin
              rdata_o <= ld_data_s;
            end else begin
              rdata_o <= rdata_o;
            end
`ifdef LSU_TIMEOUT_EN
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_r   <= ST_DONE;
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            bus_err_o <= 1'b1;
            rdata_o   <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
`else
          end else begin
            state_r <= ST_BUSY;
`endif
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          bus_err_o  <= 1'b0;
`endif
        end
        default: begin
          state_r    <= ST_IDLE;
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          bus_req_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: table of complete accesses plus reset, back-to-back
// and (with LSU_TIMEOUT_EN) timeout sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_i, mem_we_i, mem_unsigned_i;
  logic [1:0]  mem_size_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, stall_o, misalign_o, bus_err_o, bus_req_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_we_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ready_i;
  logic [31:0] bus_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
`else
  lsu_ctrl #(.ADDR_W(32)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_wdata_o(bus_wdata_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          n;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] brdata, input int n, input logic mis,
                              input logic [31:0] eaddr, input logic [3:0] ewe,
                              input logic [31:0] ewdata, input logic [31:0] erdata,
                              input int estall);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.brdata = brdata; v.n = n; v.exp_mis = mis; v.exp_addr = eaddr; v.exp_we = ewe;
    v.exp_wdata = ewdata; v.exp_rdata = erdata; v.exp_stall = estall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
    addr_i = addr; wdata_i = wdata;
  endtask

  task automatic run_access(input vec_t v, input string tag);
    int stalls = 0;
    int busy = 0;
    bit saw_req = 1'b0;
    bit fin = 1'b0;
    @(posedge clk); #1;
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    bus_ready_i = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (done_o) begin
        fin = 1'b1;
      end else begin
        if (stall_o) stalls++;
        if (bus_req_o) begin
          busy++;
          if (!saw_req) begin
            chk({tag, " bus_addr"}, bus_addr_o, v.exp_addr);
            chk({tag, " bus_we"}, {28'd0, bus_we_o}, {28'd0, v.exp_we});
            chk({tag, " bus_wdata"}, bus_wdata_o, v.exp_wdata);
          end
          saw_req = 1'b1;
          bus_ready_i = (busy == v.n);
          bus_rdata_i = (busy == v.n) ? v.brdata : 32'hA5A5_5A5A;
        end else begin
          bus_ready_i = 1'b0;
        end
      end
    end
    bus_ready_i = 1'b0;
    chk({tag, " done_reached"}, {31'd0, fin}, 32'd1);
    chk({tag, " stall_cycles"}, stalls, v.exp_stall);
    chk({tag, " bus_used"}, {31'd0, saw_req}, {31'd0, ~v.exp_mis});
    chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, v.exp_mis});
    chk({tag, " bus_err"}, {31'd0, bus_err_o}, 32'd0);
    chk({tag, " rdata"}, rdata_o, v.exp_rdata);
    chk({tag, " stall_in_done"}, {31'd0, stall_o}, 32'd0);
    // mem_req_i stays high through DONE; it must not start a second access
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    @(negedge clk);
    chk({tag, " idle_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, " idle_busreq"}, {31'd0, bus_req_o}, 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 3);
    tbl[1]  = mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80, 2);
    tbl[2]  = mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h00000080, 2);
    tbl[3]  = mk(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1, 1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080, 2);
    tbl[4]  = mk(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
    tbl[5]  = mk(1'b1, 2'b00, 1'b0, 32'h305, 32'h000000A5, 32'h0, 3, 1'b0, 32'h304, 4'b0010, 32'hA5A5A5A5, 32'h0, 4);
    tbl[6]  = mk(1'b0, 2'b01, 1'b0, 32'h402, 32'h0, 32'h80017FFF, 1, 1'b0, 32'h400, 4'b0000, 32'h0, 32'hFFFF8001, 2);
    tbl[7]  = mk(1'b0, 2'b01, 1'b1, 32'h400, 32'h0, 32'h12348765, 1, 1'b0, 32'h400, 4'b0000, 32'h0, 32'h00008765, 2);
    tbl[8]  = mk(1'b0, 2'b00, 1'b0, 32'h501, 32'h0, 32'h00007F00, 1, 1'b0, 32'h500, 4'b0000, 32'h0, 32'h0000007F, 2);
    tbl[9]  = mk(1'b1, 2'b10, 1'b0, 32'h600, 32'hCAFEF00D, 32'h0, 1, 1'b0, 32'h600, 4'b1111, 32'hCAFEF00D, 32'h0000007F, 2);
    tbl[10] = mk(1'b1, 2'b01, 1'b0, 32'h603, 32'h00001111, 32'h0, 1, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
    tbl[11] = mk(1'b0, 2'b11, 1'b0, 32'h700, 32'h0, 32'h0, 1, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
    tbl[12] = mk(1'b0, 2'b00, 1'b0, 32'h702, 32'h0, 32'h00FF0000, 1, 1'b0, 32'h700, 4'b0000, 32'h0, 32'hFFFFFFFF, 2);

    rst_n = 1'b1;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; bus_ready_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst busreq", {31'd0, bus_req_o}, 32'd0);
    chk("rst busaddr", bus_addr_o, 32'h0);
    chk("rst buswe", {28'd0, bus_we_o}, 32'd0);
    chk("rst misalign", {31'd0, misalign_o | bus_err_o}, 32'd0);
    rst_n = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_access(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-BUSY abandons the access immediately
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst busreq_before", {31'd0, bus_req_o}, 32'd1);
    rst_n = 1'b1;
    #1;
    chk("midrst busreq", {31'd0, bus_req_o}, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    mem_req_i = 1'b0;
    run_access(tbl[0], "after_rst");

    // Back-to-back: second request accepted in the IDLE cycle right after DONE
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
    @(negedge clk);
    chk("b2b idle_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    chk("b2b busreq1", {31'd0, bus_req_o}, 32'd1);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h11223344;
    @(negedge clk);
    bus_ready_i = 1'b0;
    chk("b2b done1", {31'd0, done_o}, 32'd1);
    chk("b2b rdata1", rdata_o, 32'h11223344);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b0, 32'h903, 32'h0000005A);
    @(negedge clk);
    chk("b2b idle2_done", {31'd0, done_o}, 32'd0);
    chk("b2b idle2_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    chk("b2b busreq2", {31'd0, bus_req_o}, 32'd1);
    chk("b2b busaddr2", bus_addr_o, 32'h900);
    chk("b2b buswe2", {28'd0, bus_we_o}, 32'h8);
    chk("b2b buswdata2", bus_wdata_o, 32'h5A5A5A5A);
    bus_ready_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ready_i = 1'b0;
    chk("b2b done2", {31'd0, done_o}, 32'd1);
    chk("b2b rdata_held", rdata_o, 32'h11223344);
    @(posedge clk); #1;
    mem_req_i = 1'b0;

`ifdef LSU_TIMEOUT_EN
    begin
      int req_cycles = 0;
      bit fin = 1'b0;
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 1'b0, 32'hA00, 32'h0);
      for (int c = 0; c < 40 && !fin; c++) begin
        @(negedge clk);
        if (done_o) fin = 1'b1;
        else if (bus_req_o) req_cycles++;
      end
      chk("tmo done_reached", {31'd0, fin}, 32'd1);
      chk("tmo req_cycles", req_cycles, 32'd4);
      chk("tmo bus_err", {31'd0, bus_err_o}, 32'd1);
      chk("tmo rdata", rdata_o, 32'h0);
      @(posedge clk); #1;
      mem_req_i = 1'b0;
      @(negedge clk);
      chk("tmo err_clear", {31'd0, bus_err_o}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit in the MEM stage, directly downstream of the data path's data-memory interface.
- Takes the data path's address, write data and access attributes, and turns them into a single-outstanding request on a ready-handshaked data bus.
- Performs byte-lane steering and load sign/zero extension.
- Raises stall_o to freeze the pipeline until the access completes.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 255, max BUSY cycles before bus error (only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1).
- mem_req_i  in  1  valid load/store present in MEM stage.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned_i  in  1  load zero-extends when 1.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, right-aligned.
- rdata_o  out  32  extended load result, valid while done_o = 1.
- done_o  out  1  access finished this cycle.
- stall_o  out  1  freeze pipeline.
- misalign_o  out  1  misaligned/illegal access flag, valid with done_o.
- bus_err_o  out  1  timeout flag, valid with done_o.
- bus_req_o  out  1  bus request.
- bus_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- bus_we_o  out  4  byte write strobes; 0 for loads.
- bus_wdata_o  out  32  lane-steered store data.
- bus_ready_i  in  1  bus completes transfer when bus_req_o && bus_ready_i.
- bus_rdata_i  in  32  read word, valid with bus_ready_i.

Behaviour:
- Reset (async, rst_n = 1):
  - state IDLE.
  - All outputs 0: rdata_o, done_o, stall_o, misalign_o, bus_err_o, bus_req_o, bus_addr_o, bus_we_o, bus_wdata_o.
  - Asserting reset mid-BUSY drops bus_req_o immediately; the in-flight access is abandoned.
- States: IDLE, BUSY, DONE. Two-bit encoding.
- IDLE:
  - stall_o = mem_req_i (combinational).
  - On mem_req_i, register addr, size, unsigned, we and wdata.
  - Misaligned or illegal access: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
    - Set misalign flag, go to DONE; no bus access.
  - Otherwise go to BUSY.
- BUSY:
  - bus_req_o = 1; bus_addr_o, bus_we_o and bus_wdata_o are driven from registers and are stable for the whole BUSY state.
  - stall_o = 1.
  - On bus_ready_i: capture the extended bus_rdata_i into rdata_o, go to DONE.
- DONE:
  - done_o = 1, stall_o = 0; the pipeline advances at the end of this cycle.
  - Always returns to IDLE next cycle.
  - mem_req_i seen in DONE belongs to the same instruction and is ignored.
- Latency:
  - Aligned access: 1 (IDLE) + N (BUSY, N ≥ 1) + 1 (DONE) cycles.
  - Misaligned access: 2 cycles.
  - Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.
- Store strobes:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1], 1'b0}.
  - word: 4'b1111.
- Store write data:
  - byte: replicated to all 4 lanes.
  - half: replicated to both halves.
  - word: unchanged.
- Loads:
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless mem_unsigned_i = 1.
  - Word loads pass bus_rdata_i through unchanged.
- Error and store results:
  - rdata_o = 0 on misalign or bus error.
  - rdata_o is not updated by stores; it holds its last value.
- Input stability: the pipeline holds inputs while stall_o = 1; the block relies only on the values registered in IDLE.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8+-bit counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without bus_ready_i: bus_req_o drops, bus_err_o = 1 in DONE, rdata_o = 0.
  - bus_ready_i in the same cycle as the limit wins (normal completion).
- Not defined: no counter; BUSY waits indefinitely; bus_err_o is tied 0.

Decomposition:
- Shared definitions file (lsu_defs), also used by the control path decoder:
  - size encodings SIZE_B/SIZE_H/SIZE_W/SIZE_ILL.
  - state encodings.
  - TIMEOUT default.
- One combinational sub-module, lsu_align: strobe generation, store replication, load lane select/extend. The FSM, registers and counter stay in lsu_ctrl.

Test Plan:
- Word load, addr 0x100, bus_ready_i after 2 BUSY cycles, rdata 0xDEADBEEF -> bus_addr_o 0x100, bus_we_o 0000, stall_o high 3 cycles, done_o with rdata_o 0xDEADBEEF.
- Signed byte load, addr 0x103, bus_rdata_i 0x80000000 -> rdata_o 0xFFFFFF80; same with unsigned -> 0x00000080.
- Half store 0x1234ABCD to addr 0x202 -> bus_addr_o 0x200, bus_we_o 1100, bus_wdata_o 0xABCDABCD.
- Word load at addr 0x101 -> no bus_req_o; done_o and misalign_o high in cycle 2; rdata_o 0.
- Assert rst_n during BUSY -> bus_req_o and stall_o 0 in the same cycle; next request starts from IDLE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, bus_ready_i held 0 -> bus_req_o for 4 cycles, then done_o with bus_err_o = 1.
